// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------------------+
// | hazard_scoreboard: per-register pending/ready scoreboard driving the ID-stage freeze.  |
// | Revision: 1.0                                                                          |
// +----------------------------------------------------------------------------------------+
module hazard_scoreboard #(
  parameter int REG_ADDR_W  = 5,
  parameter int LAT_W       = 3,
  parameter int ALU_LAT     = 1,
  parameter int LOAD_LAT    = 2,
  parameter int PEND_W      = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   forward_en,
  input  logic [REG_ADDR_W-1:0]  src1_id,
  input  logic [REG_ADDR_W-1:0]  src2_id,
  input  logic                   src2_valid,
  input  logic                   is_branch,
  input  logic                   issue_valid,
  input  logic                   issue_wb_en,
  input  logic [REG_ADDR_W-1:0]  issue_dest,
  input  logic                   issue_is_load,
  input  logic                   flush,
  input  logic                   wb_valid,
  input  logic [REG_ADDR_W-1:0]  wb_dest,
  output logic                   hazard_detected,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int                NUM_REGS = 2**REG_ADDR_W;
  localparam logic [LAT_W-1:0]  ALU_CNT  = LAT_W'(ALU_LAT - 1);
  localparam logic [LAT_W-1:0]  LOAD_CNT = LAT_W'(LOAD_LAT - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0]      pend_q [NUM_REGS];
  logic [PEND_W-1:0]      pend_d [NUM_REGS];
  logic [LAT_W-1:0]       cnt_q  [NUM_REGS];
  logic [LAT_W-1:0]       cnt_d  [NUM_REGS];
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic src1_busy, src2_busy;
  logic haz_src1, haz_src2, haz_struct, rec;

  // A register whose last outstanding write lands this cycle is readable through the regfile bypass.
  assign src1_busy = (pend_q[src1_id] != '0) &&
                     !(wb_valid && (wb_dest == src1_id) && (pend_q[src1_id] == PEND_W'(1)));
  assign src2_busy = (pend_q[src2_id] != '0) &&
                     !(wb_valid && (wb_dest == src2_id) && (pend_q[src2_id] == PEND_W'(1)));

  assign haz_src1 = (src1_id != '0) && src1_busy &&
                    (!forward_en || is_branch || (cnt_q[src1_id] != '0));
  assign haz_src2 = src2_valid && (src2_id != '0) && src2_busy &&
                    (!forward_en || is_branch || (cnt_q[src2_id] != '0));
  assign haz_struct = issue_valid && issue_wb_en && (issue_dest != '0) &&
                      (pend_q[issue_dest] == PEND_MAX);

  assign hazard_detected = !flush && (haz_src1 || haz_src2 || haz_struct);
  assign rec = issue_valid && issue_wb_en && (issue_dest != '0) && !flush && !hazard_detected;
  assign stall_count = stall_q;

  always_comb begin : p_next
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = pend_q[r];
      cnt_d[r]  = cnt_q[r];
      if (r != 0) begin
        inc = rec && (issue_dest == REG_ADDR_W'(r));
        dec = wb_valid && (wb_dest == REG_ADDR_W'(r)) && (pend_q[r] != '0);
        if (inc && !dec) begin
          pend_d[r] = pend_q[r] + PEND_W'(1);
        end else if (dec && !inc) begin
          pend_d[r] = pend_q[r] - PEND_W'(1);
        end
        if (inc) begin
          cnt_d[r] = issue_is_load ? LOAD_CNT : ALU_CNT;
        end else if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - LAT_W'(1);
        end
      end
    end
    stall_d = (hazard_detected && (stall_q != '1)) ? stall_q + STALL_CNT_W'(1) : stall_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      stall_q <= '0;
    end else begin
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------------------+
// | tb_hazard_scoreboard: directed and random stimulus against a cycle-time reference.      |
// | Revision: 1.0                                                                          |
// +----------------------------------------------------------------------------------------+
module tb_hazard_scoreboard;

  localparam int AW       = 5;
  localparam int NREG     = 32;
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;
  localparam int PEND_MAX = 3;
  localparam int STALL_MAX = 65535;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          forward_en, src2_valid, is_branch, issue_valid, issue_wb_en;
  logic          issue_is_load, flush, wb_valid;
  logic [AW-1:0] src1_id, src2_id, issue_dest, wb_dest;
  logic          hazard_detected;
  logic [15:0]   stall_count;

  int   n_checks = 0;
  int   n_errors = 0;
  int   pend     [NREG];
  int   ready_at [NREG];   // first cycle in which the newest producer's result is forwardable
  int   cyc      = 0;
  int   m_stall  = 0;
  logic obs_haz;

  hazard_scoreboard #(
    .REG_ADDR_W(AW), .LAT_W(3), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT),
    .PEND_W(2), .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .src1_id(src1_id), .src2_id(src2_id),
    .src2_valid(src2_valid), .is_branch(is_branch), .issue_valid(issue_valid),
    .issue_wb_en(issue_wb_en), .issue_dest(issue_dest), .issue_is_load(issue_is_load),
    .flush(flush), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .hazard_detected(hazard_detected), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle();
    forward_en = 1'b1; src1_id = '0; src2_id = '0; src2_valid = 1'b0; is_branch = 1'b0;
    issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dest = '0; issue_is_load = 1'b0;
    flush = 1'b0; wb_valid = 1'b0; wb_dest = '0;
  endtask

  task automatic issue(input int dest, input logic load);
    issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = AW'(dest); issue_is_load = load;
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin
      pend[r] = 0;
      ready_at[r] = 0;
    end
    m_stall = 0;
  endtask

  function automatic logic model_src_haz(input int s);
    logic busy;
    if (s == 0) return 1'b0;
    busy = (pend[s] > 0) && !(wb_valid && (int'(wb_dest) == s) && (pend[s] == 1));
    return busy && (!forward_en || is_branch || (cyc < ready_at[s]));
  endfunction

  function automatic logic model_haz();
    logic h;
    h = model_src_haz(int'(src1_id)) || (src2_valid && model_src_haz(int'(src2_id)));
    h = h || (issue_valid && issue_wb_en && (issue_dest != 0) && (pend[issue_dest] == PEND_MAX));
    return h && !flush;
  endfunction

  // One pipeline cycle: inputs already applied; check mid-cycle, then advance model and clock.
  task automatic tick();
    logic h, rec;
    @(negedge clk);
    h = model_haz();
    obs_haz = hazard_detected;
    check("hazard", int'(obs_haz), int'(h));
    check("stall_count", int'(stall_count), m_stall);
    rec = issue_valid && issue_wb_en && (issue_dest != 0) && !flush && !h;
    if (wb_valid && (wb_dest != 0) && (pend[wb_dest] > 0)) pend[wb_dest]--;
    if (rec) begin
      pend[issue_dest]++;
      ready_at[issue_dest] = cyc + (issue_is_load ? LOAD_LAT : ALU_LAT);
    end
    if (h && (m_stall < STALL_MAX)) m_stall++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied mid-cycle with whatever inputs are currently driven.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_hazard", int'(hazard_detected), 0);
    check("rst_stall_count", int'(stall_count), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_hazard", int'(hazard_detected), 0);
    check("reset_stall_count", int'(stall_count), 0);
    rst = 1'b0;

    // ALU producer: forwarded consumer is free; without forwarding it waits for WB.
    idle(); issue(3, 1'b0); tick();
    idle(); src1_id = 3; tick(); check("alu_fwd_no_stall", int'(obs_haz), 0);
    idle(); wb_valid = 1'b1; wb_dest = 3; tick();
    idle(); issue(3, 1'b0); tick();
    idle(); forward_en = 1'b0; src1_id = 3; tick(); check("nofwd_stall_1", int'(obs_haz), 1);
    tick(); check("nofwd_stall_2", int'(obs_haz), 1);
    wb_valid = 1'b1; wb_dest = 3; tick(); check("nofwd_wb_release", int'(obs_haz), 0);

    // Load-use with forwarding: exactly one bubble.
    idle(); do_reset();
    idle(); issue(5, 1'b1); tick();
    idle(); src2_id = 5; src2_valid = 1'b1; tick(); check("load_use_stall", int'(obs_haz), 1);
    tick(); check("load_use_go", int'(obs_haz), 0);
    check("load_stall_count", int'(stall_count), 1);
    idle(); wb_valid = 1'b1; wb_dest = 5; tick();

    // Branch operands are needed in ID: no forwarding help.
    idle(); issue(4, 1'b0); tick();
    idle(); src1_id = 4; is_branch = 1'b1; tick(); check("branch_stall_1", int'(obs_haz), 1);
    tick(); check("branch_stall_2", int'(obs_haz), 1);
    wb_valid = 1'b1; wb_dest = 4; tick(); check("branch_wb_release", int'(obs_haz), 0);

    // r0 writes are never tracked; an unread src2 never hazards; flush masks everything.
    idle(); issue(0, 1'b0); tick();
    idle(); forward_en = 1'b0; tick(); check("r0_no_hazard", int'(obs_haz), 0);
    idle(); issue(6, 1'b0); tick();
    idle(); forward_en = 1'b0; src2_id = 6; tick(); check("src2_unused", int'(obs_haz), 0);
    src2_valid = 1'b1; tick(); check("src2_used", int'(obs_haz), 1);
    flush = 1'b1; tick(); check("flush_masks", int'(obs_haz), 0);
    idle(); wb_valid = 1'b1; wb_dest = 6; tick();

    // WAW depth limit and simultaneous issue/WB.
    idle(); issue(7, 1'b0); tick(); tick(); tick();
    check("waw_third_accepted", int'(obs_haz), 0);
    tick(); check("waw_full", int'(obs_haz), 1);
    idle(); wb_valid = 1'b1; wb_dest = 7; tick();
    idle(); forward_en = 1'b0; src1_id = 7; tick(); check("waw_still_busy", int'(obs_haz), 1);
    idle(); issue(7, 1'b0); wb_valid = 1'b1; wb_dest = 7; tick();
    check("waw_issue_and_wb", int'(obs_haz), 0);
    idle(); wb_valid = 1'b1; wb_dest = 7; tick();
    idle(); forward_en = 1'b0; src1_id = 7; tick(); check("waw_last_pending", int'(obs_haz), 1);
    wb_valid = 1'b1; wb_dest = 7; tick(); check("waw_bypass_release", int'(obs_haz), 0);
    idle(); forward_en = 1'b0; src1_id = 7; tick(); check("waw_drained", int'(obs_haz), 0);

    // Random traffic over a small register window so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      forward_en    = ($urandom_range(0, 3) != 0);
      src1_id       = AW'($urandom_range(0, 7));
      src2_id       = AW'($urandom_range(0, 7));
      src2_valid    = $urandom_range(0, 1) == 1;
      is_branch     = ($urandom_range(0, 7) == 0);
      issue_valid   = $urandom_range(0, 1) == 1;
      issue_wb_en   = ($urandom_range(0, 3) != 0);
      issue_dest    = AW'($urandom_range(0, 7));
      issue_is_load = $urandom_range(0, 1) == 1;
      flush         = ($urandom_range(0, 15) == 0);
      wb_valid      = ($urandom_range(0, 2) != 0);
      wb_dest       = AW'($urandom_range(0, 7));
      if (i == 1500) begin
        #2;
        check("pre_reset_hazard", int'(hazard_detected), int'(model_haz()));
        do_reset();
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
